mult: RTL and testbench

- Sequential signed 32x32 -> 64-bit multiplier using radix-2 Booth recoding.
- Sits beside the divider in the multicycle datapath and shares its handshake: the control unit pulses a start, waits for a one-cycle done pulse, then reads hi/lo.
- Result goes to the HI/LO register pair: hi = upper word, lo = lower word of the signed product.
- One Booth step per clock; fixed latency independent of operand values.

---
 rtl/mult_if.sv | 27 ++
 rtl/mult.sv | 113 +++++++++++
 tb/tb_mult.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/mult_if.sv
// mult_if: start/done handshake and HI/LO result bus between the control
// unit and the sequential Booth multiplier.
//   a, b        : signed operands, captured by the multiplier on a start edge
//   multControl : start request from the control unit
//   multStop    : one-cycle done pulse from the multiplier
//   hi, lo      : upper/lower words of the signed 2*WIDTH-bit product
// Modports: master = control unit side, slave = multiplier side.
interface mult_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             multControl;
  logic             multStop;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output a, b, multControl,
    input  multStop, hi, lo
  );

  modport slave (
    input  a, b, multControl,
    output multStop, hi, lo
  );
endinterface

// File: rtl/mult.sv
// mult: sequential signed WIDTH x WIDTH -> 2*WIDTH multiplier, radix-2 Booth,
// one recoding step per clock, fixed latency of WIDTH steps after the start
// edge. Shares the divider's start/done handshake.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous, active-low; clears state, outputs and datapath
//   bus   : mult_if.slave -- a, b, multControl in; multStop, hi, lo out
module mult #(
  parameter int WIDTH = 32
) (
  input  logic  clk,
  input  logic  reset,
  mult_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Accumulator and multiplicand carry one extra bit so A - M with
  // M = -2^(WIDTH-1) cannot overflow.
  logic signed [WIDTH:0] m;
  logic signed [WIDTH:0] acc;
  logic [WIDTH-1:0]      q;
  logic                  q_1;
  logic [CNT_W-1:0]      cnt;

  logic signed [WIDTH:0] sum;
  logic signed [WIDTH:0] acc_shift;
  logic [WIDTH-1:0]      q_shift;
  logic                  start;
  logic                  last;

  // Booth recoding of the bit pair {Q[0], Q_1}: 01 adds M, 10 subtracts M.
  function automatic logic signed [WIDTH:0] booth_add(
    input logic signed [WIDTH:0] acc_in,
    input logic signed [WIDTH:0] m_in,
    input logic [1:0]            pair
  );
    case (pair)
      2'b01:   return acc_in + m_in;
      2'b10:   return acc_in - m_in;
      default: return acc_in;
    endcase
  endfunction

  // Combinational Booth step: add/sub, then arithmetic shift of {A,Q,Q_1}.
  always_comb begin
    sum       = booth_add(acc, m, {q[0], q_1});
    acc_shift = sum >>> 1;
    q_shift   = {sum[0], q[WIDTH-1:1]};
  end

  // A start is accepted only when no operation is in flight.
  assign start = bus.multControl && ((state == IDLE) || (state == DONE));
  assign last  = (state == RUN) && (cnt == CNT_W'(1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      m            <= '0;
      acc          <= '0;
      q            <= '0;
      q_1          <= 1'b0;
      cnt          <= '0;
      bus.hi       <= '0;
      bus.lo       <= '0;
      bus.multStop <= 1'b0;
    end else begin
      bus.multStop <= last;
      if (start) begin
        m      <= {bus.a[WIDTH-1], bus.a};
        acc    <= '0;
        q      <= bus.b;
        q_1    <= 1'b0;
        cnt    <= CNT_W'(WIDTH);
        bus.hi <= '0;
        bus.lo <= '0;
      end else if (state == RUN) begin
        acc <= acc_shift;
        q   <= q_shift;
        q_1 <= q[0];
        cnt <= cnt - CNT_W'(1);
        // The post-shift {A[WIDTH-1:0], Q} is the full signed product.
        if (last) begin
          bus.hi <= acc_shift[WIDTH-1:0];
          bus.lo <= q_shift;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult.sv
// tb_mult: directed and randomized bench for the Booth multiplier. Expected
// products come from a plain signed 64-bit multiply of the operands.
module tb_mult;

  localparam int WIDTH = 32;
  localparam int LAT   = 32;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  mult_if #(.WIDTH(WIDTH)) bus ();

  mult #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y);
    longint px, py;
    px = longint'($signed(x));
    py = longint'($signed(y));
    return 64'(px * py);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pulses multControl for one edge (edge E) and checks hi/lo were cleared.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    bus.a = x;
    bus.b = y;
    bus.multControl = 1'b1;
    tick();
    bus.multControl = 1'b0;
    check("start_clr", {bus.hi, bus.lo}, 64'd0);
    check("start_stop", {63'd0, bus.multStop}, 64'd0);
  endtask

  // Waits for multStop, counting edges since E; checks latency, result, the
  // pulse width and what hi/lo show on the following cycle.
  task automatic wait_done(input string tag, input logic [63:0] exp,
                           input int elapsed, input bit held);
    int n;
    bit seen;
    n = elapsed;
    seen = 1'b0;
    while (!seen && n < LAT + 8) begin
      tick();
      n++;
      if (bus.multStop === 1'b1) seen = 1'b1;
      else if (n == LAT / 2) check({tag, "_mid_zero"}, {bus.hi, bus.lo}, 64'd0);
    end
    check({tag, "_latency"}, 64'(n), 64'(LAT));
    check({tag, "_result"}, {bus.hi, bus.lo}, exp);
    tick();
    check({tag, "_stop_low"}, {63'd0, bus.multStop}, 64'd0);
    if (held) check({tag, "_restart_clr"}, {bus.hi, bus.lo}, 64'd0);
    else      check({tag, "_hold"}, {bus.hi, bus.lo}, exp);
  endtask

  initial begin
    logic [31:0] x, y;
    bit          any_stop;
    int          gap;

    reset = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.multControl = 1'b0;
    tick();
    tick();
    check("reset_stop", {63'd0, bus.multStop}, 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    reset = 1'b1;
    tick();

    // Directed products, including the extreme operand pairs.
    start_op(32'd3, 32'd5);
    wait_done("p3x5", 64'h00000000_0000000F, 0, 1'b0);
    start_op(32'hFFFFFFF9, 32'd6);
    wait_done("pm7x6", 64'hFFFFFFFF_FFFFFFD6, 0, 1'b0);
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done("pm1xm1", 64'h00000000_00000001, 0, 1'b0);
    start_op(32'h80000000, 32'h80000000);
    wait_done("pminxmin", 64'h40000000_00000000, 0, 1'b0);
    start_op(32'h7FFFFFFF, 32'h7FFFFFFF);
    wait_done("pmaxxmax", 64'h3FFFFFFF_00000001, 0, 1'b0);

    // Idle stability: outputs hold with multControl low.
    repeat (20) tick();
    check("idle_stop", {63'd0, bus.multStop}, 64'd0);
    check("idle_hold", {bus.hi, bus.lo}, 64'h3FFFFFFF_00000001);

    // Reset at E+10 aborts the operation without a done pulse.
    start_op(32'd3, 32'd5);
    any_stop = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (bus.multStop === 1'b1) any_stop = 1'b1;
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      if (bus.multStop === 1'b1) any_stop = 1'b1;
    end
    check("abort_no_stop", {63'd0, any_stop}, 64'd0);
    start_op(32'd2, 32'd9);
    wait_done("p2x9", 64'd18, 0, 1'b0);

    // A start request during RUN is ignored.
    start_op(32'd3, 32'd5);
    repeat (4) tick();
    bus.a = 32'd100;
    bus.b = 32'd100;
    bus.multControl = 1'b1;
    tick();
    bus.multControl = 1'b0;
    wait_done("ignore", 64'd15, 5, 1'b0);

    // multControl held high restarts on every DONE edge.
    bus.a = 32'd4;
    bus.b = 32'hFFFFFFFE;
    bus.multControl = 1'b1;
    tick();
    check("held_start_clr", {bus.hi, bus.lo}, 64'd0);
    wait_done("held1", 64'hFFFFFFFF_FFFFFFF8, 0, 1'b1);
    wait_done("held2", 64'hFFFFFFFF_FFFFFFF8, 0, 1'b1);
    wait_done("held3", 64'hFFFFFFFF_FFFFFFF8, 0, 1'b1);
    bus.multControl = 1'b0;
    wait_done("held4", 64'hFFFFFFFF_FFFFFFF8, 0, 1'b0);

    // Randomized operands; inputs are scrambled during RUN to show they are
    // captured only on the start edge.
    for (int k = 0; k < 20; k++) begin
      x = $urandom;
      y = $urandom;
      if (k == 0) x = 32'h80000000;
      if (k == 1) y = 32'h80000000;
      if (k == 2) x = 32'd0;
      start_op(x, y);
      bus.a = $urandom;
      bus.b = $urandom;
      wait_done("rand", model(x, y), 0, 1'b0);
      gap = int'($urandom_range(3, 0));
      repeat (gap) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
